// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb
// Shares one SDRAM bank port among CH requesters (channel 0 is the game).
// Arbitration is either fixed priority (lowest index wins) or round-robin,
// and a per-channel mask blocks new grants to a locked channel.
// Optional feature macro: JTFRAME_SDRAM_ARB_TIMEOUT_EN adds a 10-bit
// watchdog that drops a stuck transaction back to IDLE and raises a
// sticky err flag.
module jtframe_sdram_arb #(
    parameter int AW = 22,
    parameter int CH = 2,
    parameter int RR = 0,
    localparam int OW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             rst,
    input  logic             clk,
    // requester side
    input  logic [CH*AW-1:0] ch_addr,
    input  logic [CH-1:0]    ch_rd,
    input  logic [CH-1:0]    ch_wr,
    input  logic [CH*16-1:0] ch_din,
    input  logic [CH*2-1:0]  ch_din_m,
    input  logic [CH-1:0]    ch_mask,
    output logic [CH-1:0]    ch_ack,
    output logic [CH-1:0]    ch_dst,
    output logic [CH-1:0]    ch_rdy,
    output logic [15:0]      dout,
    // SDRAM controller bank side
    output logic [AW-1:0]    ba_addr,
    output logic             ba_rd,
    output logic             ba_wr,
    output logic [15:0]      ba_din,
    output logic [1:0]       ba_din_m,
    input  logic             ba_ack,
    input  logic             ba_dst,
    input  logic             ba_rdy,
    input  logic [15:0]      data_read,
    // status
    output logic [OW-1:0]    owner,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic [CH-1:0] eligible;
    logic          any_elig;
    logic [OW-1:0] winner;
    logic [OW-1:0] winner_next;
    int            rr_idx;
    logic          own_rd, own_wr;

    assign eligible = (ch_rd | ch_wr) & ~ch_mask;
    assign any_elig = |eligible;
    assign own_rd   = ch_rd[owner_q];
    assign own_wr   = ch_wr[owner_q];

    // Winner pick: walk candidates from last to first priority so the
    // highest-priority eligible channel is the final assignment.
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it holding its old value (no latch).
    always_comb begin
        winner = '0;
        rr_idx = 0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (RR != 0) begin
                rr_idx = (int'(ptr_q) + k) % CH;
            end else begin
                rr_idx = k;
            end
            if (eligible[rr_idx]) begin
                winner = OW'(rr_idx);
            end
        end
    end

    // Round-robin pointer moves just past the winner, wrapping to 0.
    assign winner_next = (int'(winner) == CH - 1) ? '0 : winner + 1'b1;

`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
    logic [9:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       expired;

    assign expired = (state_q != ST_IDLE) && (cnt_q == 10'h3FF);
`endif

    // Next-state, owner and pointer decode.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    owner_d = winner;
                    state_d = ST_REQ;
                    if (RR != 0) begin
                        ptr_d = winner_next;
                    end
                end
            end
            ST_REQ: begin
                // an ack wins over a simultaneous abort
                if (ba_ack) begin
                    state_d = ba_rdy ? ST_IDLE : ST_WAIT;
                end else if (!(own_rd || own_wr)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (ba_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
        if (expired) begin
            state_d = ST_IDLE;
        end
`endif
    end

    // Arbiter state registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
    // Watchdog counts while a transaction is open and clears back in IDLE.
    always_comb begin
        cnt_d = '0;
        err_d = err_q | expired;
        if (state_d != ST_IDLE && state_q != ST_IDLE) begin
            cnt_d = cnt_q + 10'd1;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy     = (state_q != ST_IDLE);
    assign owner    = owner_q;
    assign dout     = data_read;

    // Bank port always carries the owner's slice; only the strobes are gated.
    assign ba_rd    = (state_q == ST_REQ) & own_rd;
    assign ba_wr    = (state_q == ST_REQ) & own_wr;
    assign ba_addr  = ch_addr[int'(owner_q)*AW +: AW];
    assign ba_din   = ch_din[int'(owner_q)*16 +: 16];
    assign ba_din_m = ch_din_m[int'(owner_q)*2 +: 2];

    // Route bank strobes back to the owning channel only.
    always_comb begin
        ch_ack = '0;
        ch_dst = '0;
        ch_rdy = '0;
        for (int i = 0; i < CH; i++) begin
            if (int'(owner_q) == i) begin
                ch_ack[i] = ba_ack & (state_q == ST_REQ);
                ch_dst[i] = ba_dst & busy;
                ch_rdy[i] = ba_rdy & busy;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Bench for jtframe_sdram_arb: a 3-channel round-robin instance checked
// through an ack scoreboard, and a 2-channel fixed-priority instance
// checked with directed vectors. JTFRAME_SDRAM_ARB_TIMEOUT_EN selects the
// watchdog scenario.
module tb_jtframe_sdram_arb;

    localparam int AW = 22;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- round-robin instance (CH=3, RR=1) ----------------
    logic [3*AW-1:0] a_ch_addr;
    logic [2:0]      a_ch_rd, a_ch_wr, a_ch_mask;
    logic [47:0]     a_ch_din;
    logic [5:0]      a_ch_din_m;
    logic [2:0]      a_ch_ack, a_ch_dst, a_ch_rdy;
    logic [15:0]     a_dout, a_ba_din, a_data_read;
    logic [AW-1:0]   a_ba_addr;
    logic            a_ba_rd, a_ba_wr, a_ba_ack, a_ba_dst, a_ba_rdy;
    logic [1:0]      a_ba_din_m;
    logic [1:0]      a_owner;
    logic            a_busy, a_err;

    jtframe_sdram_arb #(.AW(AW), .CH(3), .RR(1)) u_rr (
        .rst(rst), .clk(clk),
        .ch_addr(a_ch_addr), .ch_rd(a_ch_rd), .ch_wr(a_ch_wr),
        .ch_din(a_ch_din), .ch_din_m(a_ch_din_m), .ch_mask(a_ch_mask),
        .ch_ack(a_ch_ack), .ch_dst(a_ch_dst), .ch_rdy(a_ch_rdy), .dout(a_dout),
        .ba_addr(a_ba_addr), .ba_rd(a_ba_rd), .ba_wr(a_ba_wr),
        .ba_din(a_ba_din), .ba_din_m(a_ba_din_m),
        .ba_ack(a_ba_ack), .ba_dst(a_ba_dst), .ba_rdy(a_ba_rdy),
        .data_read(a_data_read),
        .owner(a_owner), .busy(a_busy), .err(a_err)
    );

    // ---------------- fixed-priority instance (CH=2, RR=0) ----------------
    logic [2*AW-1:0] b_ch_addr;
    logic [1:0]      b_ch_rd, b_ch_wr, b_ch_mask;
    logic [31:0]     b_ch_din;
    logic [3:0]      b_ch_din_m;
    logic [1:0]      b_ch_ack, b_ch_dst, b_ch_rdy;
    logic [15:0]     b_dout, b_ba_din, b_data_read;
    logic [AW-1:0]   b_ba_addr;
    logic            b_ba_rd, b_ba_wr, b_ba_ack, b_ba_dst, b_ba_rdy;
    logic [1:0]      b_ba_din_m;
    logic [0:0]      b_owner;
    logic            b_busy, b_err;

    jtframe_sdram_arb #(.AW(AW), .CH(2), .RR(0)) u_fx (
        .rst(rst), .clk(clk),
        .ch_addr(b_ch_addr), .ch_rd(b_ch_rd), .ch_wr(b_ch_wr),
        .ch_din(b_ch_din), .ch_din_m(b_ch_din_m), .ch_mask(b_ch_mask),
        .ch_ack(b_ch_ack), .ch_dst(b_ch_dst), .ch_rdy(b_ch_rdy), .dout(b_dout),
        .ba_addr(b_ba_addr), .ba_rd(b_ba_rd), .ba_wr(b_ba_wr),
        .ba_din(b_ba_din), .ba_din_m(b_ba_din_m),
        .ba_ack(b_ba_ack), .ba_dst(b_ba_dst), .ba_rdy(b_ba_rdy),
        .data_read(b_data_read),
        .owner(b_owner), .busy(b_busy), .err(b_err)
    );

    // ---------------- scoreboard for the round-robin instance ----------------
    typedef struct packed {
        logic [1:0]    owner;
        logic [AW-1:0] addr;
        logic          rd;
        logic          wr;
        logic [15:0]   din;
        logic [1:0]    din_m;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] own, input logic [AW-1:0] addr,
                            input logic rd, input logic wr,
                            input logic [15:0] din, input logic [1:0] din_m);
        exp_t e;
        e.owner = own; e.addr = addr; e.rd = rd; e.wr = wr; e.din = din; e.din_m = din_m;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack presented by the round-robin DUT is matched
    // against the oldest expected transaction.
    always @(negedge clk) begin
        if (!rst && a_ch_ack != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("a_unexpected_ack", 32'(a_ch_ack), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("a_ack_owner_only", 32'(a_ch_ack), 32'(1) << mon_e.owner);
                check("a_owner", 32'(a_owner), 32'(mon_e.owner));
                check("a_addr", 32'(a_ba_addr), 32'(mon_e.addr));
                check("a_rd_wr", 32'({a_ba_rd, a_ba_wr}), 32'({mon_e.rd, mon_e.wr}));
                check("a_din", 32'({a_ba_din_m, a_ba_din}), 32'({mon_e.din_m, mon_e.din}));
            end
        end
    end

    // Bank model for the round-robin instance: ack and rdy a fixed number
    // of cycles after the request first shows on the bank port.
    task automatic a_serve(input int ack_at, input int rdy_at);
        int n = 0;
        while (!(a_ba_rd || a_ba_wr) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a_request_seen", 32'(a_ba_rd | a_ba_wr), 32'd1);
        for (int c = 1; c <= rdy_at; c++) begin
            @(posedge clk); #1;
            a_ba_ack = (c == ack_at);
            a_ba_rdy = (c == rdy_at);
        end
        @(posedge clk); #1;
        a_ba_ack = 1'b0;
        a_ba_rdy = 1'b0;
    endtask

    task automatic wait_busy_a(input string name);
        int n = 0;
        while (!a_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(a_busy), 32'd1);
    endtask

    task automatic wait_busy_b(input string name);
        int n = 0;
        while (!b_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(b_busy), 32'd1);
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst         = 1'b1;
        a_ch_addr   = {22'h102, 22'h101, 22'h100};
        a_ch_din    = {16'h1002, 16'h1001, 16'h1000};
        a_ch_din_m  = 6'b111111;
        a_ch_rd     = '0; a_ch_wr = '0; a_ch_mask = '0;
        a_ba_ack    = 1'b0; a_ba_dst = 1'b0; a_ba_rdy = 1'b0; a_data_read = 16'h0;
        b_ch_addr   = {22'h201, 22'h200};
        b_ch_din    = {16'h2001, 16'h2000};
        b_ch_din_m  = 4'b1111;
        b_ch_rd     = '0; b_ch_wr = '0; b_ch_mask = '0;
        b_ba_ack    = 1'b0; b_ba_dst = 1'b0; b_ba_rdy = 1'b0; b_data_read = 16'h0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_a_owner", 32'(a_owner), 32'd0);
        check("rst_a_strobes", 32'({a_ba_rd, a_ba_wr, a_ch_ack, a_ch_dst, a_ch_rdy}), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        check("rst_err", 32'({a_err, b_err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- round-robin: three channels reading continuously ----
        a_ch_rd = 3'b111;
        for (int g = 0; g < 6; g++) begin
            push_exp(2'(g % 3), 22'h100 + 22'(g % 3), 1'b1, 1'b0, 16'h1000 + 16'(g % 3), 2'b11);
            a_serve(2, 4);
        end
        a_ch_rd = 3'b000;
        @(negedge clk);
        check("a_rr_all_acked", 32'(exp_q.size()), 32'd0);

        // ---- mask blocks a new grant; clearing it grants next cycle ----
        @(posedge clk); #1;
        a_ch_mask = 3'b001;
        a_ch_rd   = 3'b001;
        repeat (3) @(negedge clk);
        check("a_masked_busy", 32'(a_busy), 32'd0);
        check("a_masked_rd", 32'(a_ba_rd), 32'd0);
        @(posedge clk); #1;
        a_ch_mask = 3'b000;
        @(negedge clk);
        check("a_unmask_same_cycle", 32'(a_busy), 32'd0);
        @(negedge clk);
        check("a_unmask_grant", 32'({a_busy, a_owner}), 32'({1'b1, 2'd0}));
        push_exp(2'd0, 22'h100, 1'b1, 1'b0, 16'h1000, 2'b11);
        a_serve(2, 4);
        a_ch_rd = 3'b000;

        // ---- owner 1 write with data strobe ----
        a_ch_din[16 +: 16]  = 16'hA55A;
        a_ch_din_m[2 +: 2]  = 2'b01;
        a_ch_wr             = 3'b010;
        wait_busy_a("a_wr_grant");
        check("a_wr_owner", 32'(a_owner), 32'd1);
        check("a_wr_bank", 32'({a_ba_rd, a_ba_wr, a_ba_din_m, a_ba_din}), 32'({1'b0, 1'b1, 2'b01, 16'hA55A}));
        push_exp(2'd1, 22'h101, 1'b0, 1'b1, 16'hA55A, 2'b01);
        @(negedge clk);
        check("a_wr_held", 32'(a_ba_wr), 32'd1);
        @(posedge clk); #1;
        a_ba_ack = 1'b1;
        @(posedge clk); #1;
        a_ba_ack = 1'b0;
        a_ch_wr  = 3'b000;
        @(negedge clk);
        check("a_wait_no_wr", 32'(a_ba_wr), 32'd0);
        check("a_wait_din", 32'(a_ba_din), 32'h0000A55A);
        @(posedge clk); #1;
        a_ba_dst    = 1'b1;
        a_data_read = 16'h1234;
        @(negedge clk);
        check("a_dst_routed", 32'(a_ch_dst), 32'b010);
        check("a_dout", 32'(a_dout), 32'h1234);
        @(posedge clk); #1;
        a_ba_dst = 1'b0;
        a_ba_rdy = 1'b1;
        @(negedge clk);
        check("a_rdy_routed", 32'(a_ch_rdy), 32'b010);
        @(posedge clk); #1;
        a_ba_rdy = 1'b0;
        @(negedge clk);
        check("a_wr_done_idle", 32'(a_busy), 32'd0);

        // ---- reset pulse while in WAIT ----
        a_ch_rd = 3'b100;
        wait_busy_a("a_rst_grant");
        push_exp(2'd2, 22'h102, 1'b1, 1'b0, 16'h1002, 2'b11);
        @(posedge clk); #1;
        a_ba_ack = 1'b1;
        @(posedge clk); #1;
        a_ba_ack = 1'b0;
        @(negedge clk);
        check("a_in_wait", 32'({a_busy, a_ba_rd}), 32'({1'b1, 1'b0}));
        @(posedge clk); #3;
        rst      = 1'b1;
        a_ba_dst = 1'b1;
        a_ba_rdy = 1'b1;
        #1;
        check("a_rst_async_busy", 32'(a_busy), 32'd0);
        check("a_rst_async_owner", 32'(a_owner), 32'd0);
        check("a_rst_async_strobes", 32'({a_ba_rd, a_ba_wr, a_ch_ack, a_ch_dst, a_ch_rdy}), 32'd0);
        a_ch_rd = 3'b000;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("a_late_rdy_dropped", 32'({a_ch_rdy, a_ch_dst}), 32'd0);
        check("a_idle_after_rst", 32'(a_busy), 32'd0);
        @(posedge clk); #1;
        a_ba_dst = 1'b0;
        a_ba_rdy = 1'b0;

        // ---- fixed priority: simultaneous requests ----
        b_ch_rd = 2'b11;
        @(negedge clk);
        check("b_no_same_cycle_grant", 32'({b_busy, b_ba_rd}), 32'd0);
        @(negedge clk);
        check("b_low_index_wins", 32'({b_owner, b_ba_rd}), 32'({1'b0, 1'b1}));
        check("b_addr0", 32'(b_ba_addr), 32'h200);
        @(posedge clk); #1;
        b_ba_ack = 1'b1;
        @(negedge clk);
        check("b_ack0", 32'(b_ch_ack), 32'b01);
        @(posedge clk); #1;
        b_ba_ack = 1'b0;
        b_ch_rd  = 2'b10;
        repeat (2) @(negedge clk);
        check("b_ch1_waits", 32'({b_busy, b_owner, b_ba_rd}), 32'({1'b1, 1'b0, 1'b0}));
        @(posedge clk); #1;
        b_ba_rdy = 1'b1;
        @(negedge clk);
        check("b_rdy0", 32'(b_ch_rdy), 32'b01);
        @(posedge clk); #1;
        b_ba_rdy = 1'b0;
        @(negedge clk);
        check("b_no_grant_on_rdy", 32'(b_busy), 32'd0);
        @(negedge clk);
        check("b_ch1_served", 32'({b_owner, b_ba_rd}), 32'({1'b1, 1'b1}));
        check("b_addr1", 32'(b_ba_addr), 32'h201);

        // ---- abort before ack ----
        @(posedge clk); #1;
        b_ch_rd = 2'b00;
        @(negedge clk);
        check("b_abort_strobe_drop", 32'({b_busy, b_ba_rd}), 32'({1'b1, 1'b0}));
        @(negedge clk);
        check("b_abort_idle", 32'({b_busy, b_ch_ack}), 32'd0);

        // ---- ack and rdy together in REQ; rd and wr both high ----
        @(posedge clk); #1;
        b_ch_rd = 2'b10;
        b_ch_wr = 2'b10;
        wait_busy_b("b_both_grant");
        check("b_both_strobes", 32'({b_owner, b_ba_rd, b_ba_wr}), 32'({1'b1, 1'b1, 1'b1}));
        @(posedge clk); #1;
        b_ba_ack = 1'b1;
        b_ba_rdy = 1'b1;
        @(negedge clk);
        check("b_ack_rdy_same", 32'({b_ch_ack, b_ch_rdy}), 32'({2'b10, 2'b10}));
        @(posedge clk); #1;
        b_ba_ack = 1'b0;
        b_ba_rdy = 1'b0;
        b_ch_rd  = 2'b00;
        b_ch_wr  = 2'b00;
        @(negedge clk);
        check("b_direct_idle", 32'(b_busy), 32'd0);

`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
        // ---- bank never answers: watchdog returns to IDLE and sets err ----
        @(posedge clk); #1;
        b_ch_rd = 2'b01;
        wait_busy_b("b_to_grant");
        n = 0;
        while (b_busy && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("b_to_cycles_in_range", 32'(n >= 1020 && n <= 1026), 32'd1);
        check("b_to_err", 32'(b_err), 32'd1);
        check("b_to_no_rdy", 32'(b_ch_rdy), 32'd0);
        @(negedge clk);
        check("b_to_regrant", 32'({b_busy, b_owner, b_ba_rd}), 32'({1'b1, 1'b0, 1'b1}));
        @(posedge clk); #1;
        b_ba_ack = 1'b1;
        b_ba_rdy = 1'b1;
        @(negedge clk);
        check("b_to_regrant_ack", 32'(b_ch_ack), 32'b01);
        @(posedge clk); #1;
        b_ba_ack = 1'b0;
        b_ba_rdy = 1'b0;
        b_ch_rd  = 2'b00;
        @(negedge clk);
        check("b_to_err_sticky", 32'({b_busy, b_err}), 32'({1'b0, 1'b1}));
`else
        n = 0;
        check("b_err_tied_low", 32'({a_err, b_err}), 32'(n));
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
